crc_tx_scheduler: RTL and testbench
===================================

Name: crc_tx_scheduler

Overview:
- Round-robin scheduler that shares one bit-serial CRC-4 encoder among NUM_REQ transmit requesters.
- Accepts one 11-bit payload per grant, computes the CRC over 11 cycles, then presents a 15-bit codeword with a source tag to the downstream link.
- The codeword format matches the transmit path: data_out[14:4] = payload, data_out[3:0] = CRC.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SRC_W, 2, width of the source tag; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester payload valid.
- req_data  in  NUM_REQ*11  payload of requester i on bits [11*i+10 : 11*i].
- req_ready  out  NUM_REQ  one-hot acceptance strobe (combinational).
- data_out  out  15  codeword {payload, crc[3:0]}.
- out_src  out  SRC_W  index of the requester that owns data_out.
- out_valid  out  1  codeword valid.
- out_ready  in  1  downstream accepts the codeword.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - One clock; reset is synchronous and active-high.
  - Every output is 0 while reset is high.
  - state=IDLE, rr_ptr=0, crc=0, bit counter=0.
  - A reset in any state, including mid-CALC or DONE, aborts the frame. Nothing is emitted, and no req_ready is issued in the reset cycle.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If any req_valid is high, grant the first valid index found by searching from rr_ptr upward with wrap.
  - req_ready[g]=1 in that same cycle; all other req_ready bits are 0.
  - At the clock edge: capture the payload into a shift register, clear crc, set counter=10, set out_src=g, set rr_ptr=(g+1) mod NUM_REQ, go to CALC.
  - With no valid request: stay in IDLE with all req_ready=0.
- CALC, once per cycle, MSB first:
  - b = shift[10]; fb = crc[3]^b.
  - crc <= {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000); shift left by 1.
  - This is polynomial x^4+x+1, init 0, no reflection, no final XOR.
  - After the 11th bit (counter reaches 0): load data_out={payload, crc_next}, set out_valid=1, go to DONE.
- DONE:
  - Hold data_out, out_src and out_valid stable until out_valid && out_ready.
  - On that handshake edge: out_valid <= 0, go to IDLE.
  - No new grant is issued in DONE.
- Timing:
  - out_valid rises 12 cycles after the acceptance cycle.
  - Minimum spacing between grants is 13 cycles.
- Requester rules:
  - A requester holds req_valid and its payload until it sees req_ready.
  - req_valid changes in CALC or DONE have no effect.
  - A requester whose valid drops before it is granted is simply skipped.
- out_ready while out_valid=0 is ignored.
- data_out and out_src keep their last values after the handshake, until the next load or reset.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.

Test Plan:
- Single requester 0, payload 11'h001, out_ready=1 → req_ready=4'b0001 for one cycle; 12 cycles later out_valid=1, data_out=15'h0013, out_src=0; busy low the cycle after the handshake.
- Payloads 11'h000 and 11'h400 on requester 2 → codewords 15'h0000 and 15'h4009, out_src=2.
- All four req_valid held high with distinct payloads, out_ready=1 → grant order 0,1,2,3,0; successive req_ready pulses exactly 13 cycles apart.
- Backpressure: out_ready=0 for 20 cycles after out_valid → data_out/out_src stable and no req_ready pulses during the stall; handshake after out_ready=1, then the next grant goes to the next valid index after the previous grant.
- Reset asserted at CALC cycle 5, with req_valid of requester 1 held → the cycle after reset deasserts, outputs are 0 and the FSM is in IDLE; requester 0 (rr_ptr=0) is granted next if valid, otherwise requester 1; no stale codeword ever appears.
- Requester 3 raises then drops req_valid while a frame is in CALC, requester 1 stays valid → the next grant goes to 1; req_ready[3] never pulses.

Source files
------------

// File: rtl/crc_tx_scheduler_if.sv
// Bus between the transmit requesters, the shared CRC scheduler and the downstream link.
interface crc_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*11-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [14:0]           data_out;
    logic [SRC_W-1:0]      out_src;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;

    // Requester / link side.
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, data_out, out_src, out_valid, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, data_out, out_src, out_valid, busy
    );
endinterface

// File: rtl/crc_tx_scheduler.sv
// Round-robin scheduler sharing one bit-serial CRC-4 (x^4+x+1) encoder among
// NUM_REQ requesters; emits {payload, crc} codewords tagged with the source index.
module crc_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    crc_tx_scheduler_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg,   state_next;
    logic [SRC_W-1:0] rr_ptr_reg,  rr_ptr_next;
    logic [10:0]      shift_reg,   shift_next;
    logic [10:0]      payload_reg, payload_next;
    logic [3:0]       crc_reg,     crc_next;
    logic [3:0]       cnt_reg,     cnt_next;
    logic [SRC_W-1:0] src_reg,     src_next;
    logic [14:0]      data_reg,    data_next;
    logic             valid_reg,   valid_next;

    logic [10:0]        payload_arr [NUM_REQ];
    logic               grant_found;
    logic [SRC_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] ready_comb;
    logic               fb;
    logic [3:0]         crc_step;

    // Unpack the flat payload bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_payload
            assign payload_arr[gi] = bus.req_data[11*gi +: 11];
        end
    endgenerate

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int cand;
            cand = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(cand);
            end
        end
    end

    // One LFSR step, MSB of the payload shift register first.
    assign fb       = crc_reg[3] ^ shift_reg[10];
    assign crc_step = {crc_reg[2:0], 1'b0} ^ {2'b00, fb, fb};

    // Next-state and datapath decisions for the IDLE/CALC/DONE frame sequence.
    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        shift_next   = shift_reg;
        payload_next = payload_reg;
        crc_next     = crc_reg;
        cnt_next     = cnt_reg;
        src_next     = src_reg;
        data_next    = data_reg;
        valid_next   = valid_reg;
        ready_comb   = '0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    ready_comb[grant_idx] = 1'b1;
                    shift_next   = payload_arr[grant_idx];
                    payload_next = payload_arr[grant_idx];
                    crc_next     = 4'd0;
                    cnt_next     = 4'd10;
                    src_next     = grant_idx;
                    rr_ptr_next  = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0
                                                                      : grant_idx + SRC_W'(1);
                    state_next   = CALC;
                end
            end
            CALC: begin
                crc_next   = crc_step;
                shift_next = {shift_reg[9:0], 1'b0};
                if (cnt_reg == 4'd0) begin
                    data_next  = {payload_reg, crc_step};
                    valid_next = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            shift_reg   <= '0;
            payload_reg <= '0;
            crc_reg     <= '0;
            cnt_reg     <= '0;
            src_reg     <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            shift_reg   <= shift_next;
            payload_reg <= payload_next;
            crc_reg     <= crc_next;
            cnt_reg     <= cnt_next;
            src_reg     <= src_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
        end
    end

    // Outputs are forced low for the whole reset cycle, including the grant strobe.
    assign bus.req_ready = reset ? '0 : ready_comb;
    assign bus.data_out  = reset ? '0 : data_reg;
    assign bus.out_src   = reset ? '0 : src_reg;
    assign bus.out_valid = !reset && valid_reg;
    assign bus.busy      = !reset && (state_reg != IDLE);

endmodule

// File: tb/tb_crc_tx_scheduler.sv
// Self-checking bench for crc_tx_scheduler: cycle-level reference model plus directed scenarios.
module tb_crc_tx_scheduler;

    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    crc_tx_scheduler_if #(.NUM_REQ(N), .SRC_W(SW)) bus ();
    crc_tx_scheduler #(.NUM_REQ(N), .SRC_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    // Per-requester payload lists; a requester offers its list head until granted.
    logic [10:0] plist [N][8];
    int          pcount [N];
    int          phead [N];
    bit          grant_seen [N];

    // Event logs gathered from the DUT.
    int          glog [$];
    int          gcyc [$];
    logic [14:0] hs_data [$];
    int          hs_src [$];
    int          hs_cyc [$];
    int          cyc = 0;

    // Reference model state.
    int          m_phase;   // 0 idle, 11..1 bits left to encode, 12 holding codeword
    int          m_ptr;
    int          m_src;
    logic [14:0] m_word;
    logic [14:0] m_data;

    logic [N-1:0] exp_ready;
    logic         exp_valid, exp_busy;
    logic [14:0]  exp_data;
    int           exp_src;

    // CRC as the remainder of payload*x^4 divided by x^4+x+1 (polynomial long division).
    function automatic logic [3:0] crc4(input logic [10:0] p);
        logic [14:0] r;
        r = {p, 4'b0000};
        for (int i = 14; i >= 4; i--)
            if (r[i]) r = r ^ (15'b10011 << (i - 4));
        return r[3:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock, then update requester drives after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (grant_seen[i]) begin
                phead[i]++;
                grant_seen[i] = 1'b0;
            end
            bus.req_valid[i]         = (phead[i] < pcount[i]);
            bus.req_data[11*i +: 11] = (phead[i] < pcount[i]) ? plist[i][phead[i]] : 11'h000;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            pcount[i] = 0;
            phead[i] = 0;
            grant_seen[i] = 1'b0;
        end
        tick();
        tick();
        reset = 1'b0;
        glog.delete(); gcyc.delete();
        hs_data.delete(); hs_src.delete(); hs_cyc.delete();
    endtask

    task automatic wait_grants(input int n, input int budget);
        int b = 0;
        while (glog.size() < n && b < budget) begin tick(); b++; end
        check("grant_wait", glog.size() >= n, 1);
    endtask

    task automatic wait_hs(input int n, input int budget);
        int b = 0;
        while (hs_data.size() < n && b < budget) begin tick(); b++; end
        check("handshake_wait", hs_data.size() >= n, 1);
    endtask

    initial begin
        int n3;
        logic [14:0] held_data;
        logic [1:0]  held_src;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        m_phase = 0; m_ptr = 0; m_src = 0; m_word = '0; m_data = '0;
        for (int i = 0; i < N; i++) begin
            pcount[i] = 0; phead[i] = 0; grant_seen[i] = 1'b0;
        end

        fork
            // Per-cycle compare against the model, plus event logging.
            forever begin
                @(negedge clk);
                cyc++;
                exp_ready = '0;
                if (reset) begin
                    exp_valid = 1'b0; exp_busy = 1'b0; exp_data = '0; exp_src = 0;
                end else begin
                    exp_valid = (m_phase == 12);
                    exp_busy  = (m_phase != 0);
                    exp_data  = m_data;
                    exp_src   = m_src;
                end
                begin
                    int g;
                    g = -1;
                    if (!reset && m_phase == 0)
                        for (int k = 0; k < N; k++)
                            if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                    if (g >= 0) exp_ready[g] = 1'b1;
                    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
                    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
                    check("busy", 32'(bus.busy), 32'(exp_busy));
                    check("data_out", 32'(bus.data_out), 32'(exp_data));
                    check("out_src", 32'(bus.out_src), 32'(exp_src));

                    if (!reset) begin
                        for (int i = 0; i < N; i++)
                            if (bus.req_ready[i]) begin
                                glog.push_back(i); gcyc.push_back(cyc); grant_seen[i] = 1'b1;
                            end
                        if (bus.out_valid && bus.out_ready) begin
                            hs_data.push_back(bus.data_out);
                            hs_src.push_back(int'(bus.out_src));
                            hs_cyc.push_back(cyc);
                        end
                    end

                    if (reset) begin
                        m_phase = 0; m_ptr = 0; m_src = 0; m_data = '0;
                    end else if (m_phase == 0) begin
                        if (g >= 0) begin
                            logic [10:0] p;
                            p       = bus.req_data[11*g +: 11];
                            m_word  = {p, crc4(p)};
                            m_src   = g;
                            m_ptr   = (g + 1) % N;
                            m_phase = 11;
                        end
                    end else if (m_phase == 12) begin
                        if (bus.out_ready) m_phase = 0;
                    end else begin
                        if (m_phase == 1) begin
                            m_data  = m_word;
                            m_phase = 12;
                        end else begin
                            m_phase--;
                        end
                    end
                end
            end
        join_none

        // Pin the reference CRC against hand-computed values.
        check("model_crc_001", 32'(crc4(11'h001)), 32'h3);
        check("model_crc_400", 32'(crc4(11'h400)), 32'h9);
        check("model_crc_000", 32'(crc4(11'h000)), 32'h0);

        tick(); tick();
        apply_reset();

        // Single requester 0, payload 0x001.
        plist[0][0] = 11'h001; pcount[0] = 1;
        wait_grants(1, 20);
        wait_hs(1, 30);
        check("t1_grant_idx", glog[0], 0);
        check("t1_codeword", 32'(hs_data[0]), 32'h0013);
        check("t1_src", hs_src[0], 0);
        check("t1_latency", hs_cyc[0] - gcyc[0], 12);
        check("t1_busy_after_hs", 32'(bus.busy), 0);
        tick(); tick();

        // Requester 2, payloads 0x000 and 0x400.
        apply_reset();
        plist[2][0] = 11'h000; plist[2][1] = 11'h400; pcount[2] = 2;
        wait_hs(2, 60);
        check("t2_cw0", 32'(hs_data[0]), 32'h0000);
        check("t2_cw1", 32'(hs_data[1]), 32'h4009);
        check("t2_src0", hs_src[0], 2);
        check("t2_src1", hs_src[1], 2);

        // All four requesters valid: rotation and 13-cycle grant spacing.
        apply_reset();
        plist[0][0] = 11'h155; plist[0][1] = 11'h7FF; pcount[0] = 2;
        plist[1][0] = 11'h2AA; pcount[1] = 1;
        plist[2][0] = 11'h0F0; pcount[2] = 1;
        plist[3][0] = 11'h30C; pcount[3] = 1;
        wait_grants(5, 100);
        for (int i = 0; i < 5; i++) check("t3_order", glog[i], i % N);
        for (int i = 1; i < 5; i++) check("t3_spacing", gcyc[i] - gcyc[i-1], 13);
        wait_hs(5, 40);

        // Backpressure: 20-cycle stall, then handshake and next grant.
        apply_reset();
        bus.out_ready = 1'b0;
        plist[1][0] = 11'h001; pcount[1] = 1;
        plist[2][0] = 11'h400; pcount[2] = 1;
        wait_grants(1, 20);
        begin
            int b = 0;
            while (!bus.out_valid && b < 30) begin tick(); b++; end
        end
        check("t4_valid_seen", 32'(bus.out_valid), 1);
        held_data = bus.data_out;
        held_src  = bus.out_src;
        for (int i = 0; i < 20; i++) tick();
        check("t4_stall_grants", glog.size(), 1);
        check("t4_hold_data", 32'(bus.data_out), 32'(held_data));
        check("t4_hold_src", 32'(bus.out_src), 32'(held_src));
        check("t4_stall_data", 32'(held_data), 32'h0013);
        bus.out_ready = 1'b1;
        wait_grants(2, 20);
        check("t4_next_grant", glog[1], 2);
        wait_hs(2, 40);
        check("t4_cw2", 32'(hs_data[1]), 32'h4009);

        // Reset in CALC cycle 5 with requester 1 still holding a request.
        apply_reset();
        plist[1][0] = 11'h0AB; plist[1][1] = 11'h001; pcount[1] = 2;
        wait_grants(1, 20);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_post_data", 32'(bus.data_out), 0);
        check("t5_post_valid", 32'(bus.out_valid), 0);
        check("t5_post_busy", 32'(bus.busy), 0);
        wait_grants(2, 20);
        check("t5_regrant", glog[1], 1);
        wait_hs(1, 40);
        for (int i = 0; i < 5; i++) tick();
        check("t5_hs_count", hs_data.size(), 1);
        check("t5_cw", 32'(hs_data[0]), 32'h0013);
        check("t5_src", hs_src[0], 1);

        // Requester 3 raises then drops valid during CALC; requester 1 is next.
        apply_reset();
        plist[0][0] = 11'h400; pcount[0] = 1;
        wait_grants(1, 20);
        tick(); tick(); tick();
        plist[3][0] = 11'h123; pcount[3] = 1;
        tick(); tick();
        pcount[3] = 0;
        plist[1][0] = 11'h001; pcount[1] = 1;
        wait_grants(2, 40);
        check("t6_next_grant", glog[1], 1);
        wait_hs(2, 40);
        n3 = 0;
        foreach (glog[i]) if (glog[i] == 3) n3++;
        check("t6_req3_pulses", n3, 0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
